// File: rtl/config_chain_readback.sv
// config_chain_readback: non-destructive LSB-first word readback of a recirculating configuration chain
module config_chain_readback #(
   parameter int CHAIN_LEN = 64,
   parameter int WORD_W = 8
) (
   input  logic              prog_clk,
   input  logic              pReset,
   input  logic              start,
   input  logic              ccff_tail,
   output logic              ccff_head,
   output logic              ccff_shift_en,
   output logic [WORD_W-1:0] rd_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic              busy,
   output logic              done
);
   localparam int CW = $clog2(CHAIN_LEN + 1);
   localparam int KW = $clog2(WORD_W + 1);
   localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN - 1);
   localparam logic [CW-1:0] FULL = CW'(CHAIN_LEN);
   localparam logic [KW-1:0] WLAST = KW'(WORD_W - 1);
   typedef enum logic [1:0] {IDLE, SHIFT, HOLD, DONE} state_t;
   state_t state;
   logic [CW-1:0] cnt;
   logic [KW-1:0] k;
   logic [WORD_W-1:0] wbuf;
   logic last, fin;
   assign ccff_head = ccff_tail;
   assign rd_data = wbuf;
   assign last = k == WLAST || cnt == LAST;
   assign fin = cnt == FULL;
   always_ff @(posedge prog_clk)
      if (pReset) begin
         state <= IDLE;
         cnt <= '0;
         k <= '0;
         wbuf <= '0;
         ccff_shift_en <= 1'b0;
         rd_valid <= 1'b0;
         busy <= 1'b0;
         done <= 1'b0;
      end else
         case (state)
            IDLE: if (start) begin
               state <= SHIFT;
               cnt <= '0;
               k <= '0;
               wbuf <= '0;
               busy <= 1'b1;
               ccff_shift_en <= 1'b1;
            end
            SHIFT: begin
               wbuf <= wbuf | (WORD_W'(ccff_tail) << k);
               cnt <= cnt + 1'b1;
               k <= last ? '0 : k + 1'b1;
               state <= last ? HOLD : SHIFT;
               ccff_shift_en <= !last;
               rd_valid <= last;
            end
            HOLD: if (rd_ready) begin
               wbuf <= '0;
               rd_valid <= 1'b0;
               state <= fin ? DONE : SHIFT;
               done <= fin;
               ccff_shift_en <= !fin;
            end
            DONE: begin
               state <= IDLE;
               done <= 1'b0;
               busy <= 1'b0;
            end
         endcase
endmodule
